// File: rtl/instruction_loader.sv
// Loads a length-prefixed byte stream into instruction RAM as big-endian 32-bit words.
// Stream format: count[10:8], count[7:0], then 4*count data bytes.
module instruction_loader #(
  parameter logic [9:0] BASE_ADDRESS = 10'd0,
  parameter int         MAX_WORDS    = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [31:0] i_ram_input,
  output logic [9:0]  i_ram_writing_address,
  output logic        flag_write_i_ram,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [2:0]  fsm_state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COUNT_HI = 3'd1,
    COUNT_LO = 3'd2,
    DATA     = 3'd3,
    WRITE    = 3'd4,
    FINISH   = 3'd5,
    ERROR    = 3'd6
  } state_t;

  localparam logic [11:0] MAX_COUNT = 12'(MAX_WORDS);

  state_t      state;
  logic [10:0] count;
  logic [10:0] word_index;
  logic [1:0]  byte_cnt;
  logic [23:0] word;

  // Handshake: a byte moves only on a rising edge where byte_valid and
  // byte_ready are both 1; byte_ready is a registered function of state.
  logic        accept;
  logic [10:0] count_lo_next;
  logic [10:0] word_index_next;

  assign accept          = byte_valid & byte_ready;
  assign count_lo_next   = {count[10:8], byte_in};
  assign word_index_next = word_index + 11'd1;
  assign fsm_state       = state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state                 <= IDLE;
      count                 <= '0;
      word_index            <= '0;
      byte_cnt              <= '0;
      word                  <= '0;
      byte_ready            <= 1'b0;
      i_ram_input           <= '0;
      i_ram_writing_address <= BASE_ADDRESS;
      flag_write_i_ram      <= 1'b0;
      busy                  <= 1'b0;
      done                  <= 1'b0;
      error                 <= 1'b0;
    end else begin
      done             <= 1'b0;
      flag_write_i_ram <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= COUNT_HI;
            byte_ready <= 1'b1;
            busy       <= 1'b1;
            error      <= 1'b0;
            count      <= '0;
            word_index <= '0;
            byte_cnt   <= '0;
          end
        end
        COUNT_HI: begin
          if (accept) begin
            count[10:8] <= byte_in[2:0];
            state       <= COUNT_LO;
          end
        end
        COUNT_LO: begin
          if (accept) begin
            count[7:0] <= byte_in;
            if (count_lo_next == 11'd0) begin
              state      <= FINISH;
              byte_ready <= 1'b0;
              done       <= 1'b1;
            end else if ({1'b0, count_lo_next} > MAX_COUNT) begin
              state      <= ERROR;
              byte_ready <= 1'b0;
              error      <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            word     <= {word[15:0], byte_in};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state                 <= WRITE;
              byte_ready            <= 1'b0;
              byte_cnt              <= '0;
              flag_write_i_ram      <= 1'b1;
              i_ram_input           <= {word, byte_in};
              i_ram_writing_address <= BASE_ADDRESS + word_index[9:0];
            end
          end
        end
        WRITE: begin
          word_index <= word_index_next;
          if (word_index_next == count) begin
            state <= FINISH;
            done  <= 1'b1;
          end else begin
            state      <= DATA;
            byte_ready <= 1'b1;
          end
        end
        FINISH, ERROR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          byte_ready <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: two instances (base 0 and base 1023)
// share one stimulus stream; writes are captured and compared against expected queues.
module tb_instruction_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;

  logic        byte_ready0, byte_ready1;
  logic [31:0] data0, data1;
  logic [9:0]  addr0, addr1;
  logic        wr0, wr1;
  logic        busy0, busy1;
  logic        done0, done1;
  logic        error0, error1;
  logic [2:0]  state0, state1;

  logic [41:0] exp_q0[$];
  logic [41:0] exp_q1[$];
  logic [41:0] got_q0[$];
  logic [41:0] got_q1[$];

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  instruction_loader #(.BASE_ADDRESS(10'd0), .MAX_WORDS(1024)) dut0 (
    .clock(clock), .reset(reset), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready0), .i_ram_input(data0),
    .i_ram_writing_address(addr0), .flag_write_i_ram(wr0), .busy(busy0),
    .done(done0), .error(error0), .fsm_state(state0)
  );

  instruction_loader #(.BASE_ADDRESS(10'd1023), .MAX_WORDS(1024)) dut1 (
    .clock(clock), .reset(reset), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready1), .i_ram_input(data1),
    .i_ram_writing_address(addr1), .flag_write_i_ram(wr1), .busy(busy1),
    .done(done1), .error(error1), .fsm_state(state1)
  );

  // Capture every strobed write; a strobe lasting two cycles shows up as an extra entry.
  always @(negedge clock) begin
    if (wr0) got_q0.push_back({addr0, data0});
    if (wr1) got_q1.push_back({addr1, data1});
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    byte_valid = 1'b0;
    repeat (gap) tick();
    byte_in = b;
    byte_valid = 1'b1;
    n = 0;
    while (!byte_ready0 && n < 20) begin
      tick();
      n++;
    end
    chk("byte_ready0", byte_ready0, 1'b1);
    chk("byte_ready1", byte_ready1, 1'b1);
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic expect_write(input logic [10:0] idx, input logic [31:0] w);
    logic [9:0] a0;
    logic [9:0] a1;
    a0 = 10'd0 + idx[9:0];
    a1 = 10'd1023 + idx[9:0];
    exp_q0.push_back({a0, w});
    exp_q1.push_back({a1, w});
  endtask

  task automatic check_writes(input string tag);
    logic [41:0] e;
    logic [41:0] g;
    chk({tag, "_count0"}, got_q0.size(), exp_q0.size());
    chk({tag, "_count1"}, got_q1.size(), exp_q1.size());
    while (got_q0.size() > 0 && exp_q0.size() > 0) begin
      e = exp_q0.pop_front();
      g = got_q0.pop_front();
      chk({tag, "_write0"}, g, e);
    end
    while (got_q1.size() > 0 && exp_q1.size() > 0) begin
      e = exp_q1.pop_front();
      g = got_q1.pop_front();
      chk({tag, "_write1"}, g, e);
    end
    got_q0.delete(); got_q1.delete(); exp_q0.delete(); exp_q1.delete();
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    repeat (2) tick();
    chk("rst_busy", busy0, 1'b0);
    chk("rst_ready", byte_ready0, 1'b0);
    chk("rst_wr", wr0, 1'b0);
    chk("rst_done", done0, 1'b0);
    chk("rst_error", error0, 1'b0);
    chk("rst_data", data0, 32'h0);
    chk("rst_addr0", addr0, 10'd0);
    chk("rst_addr1", addr1, 10'd1023);
    chk("rst_state", state0, 3'd0);
    reset = 1'b0;
    tick();

    // Two-word load; base 1023 instance also exercises address wrap
    pulse_start();
    chk("t1_busy", busy0, 1'b1);
    chk("t1_state_hi", state0, 3'd1);
    expect_write(11'd0, 32'h6C00_0000);
    expect_write(11'd1, 32'h7440_0000);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h6C, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    chk("t1_strobe_w0", wr0, 1'b1);
    chk("t1_ready_in_write", byte_ready0, 1'b0);
    send_byte(8'h74, 0);
    send_byte(8'h40, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    chk("t1_strobe_w1", wr0, 1'b1);
    chk("t1_addr1_wrap", addr1, 10'd0);
    tick();
    chk("t1_done", done0, 1'b1);
    chk("t1_no_strobe_finish", wr0, 1'b0);
    chk("t1_error1", error1, 1'b0);
    tick();
    chk("t1_done_off", done0, 1'b0);
    chk("t1_idle_busy", busy0, 1'b0);
    check_writes("t1");

    // Zero-length load
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    chk("t2_done", done0, 1'b1);
    chk("t2_busy", busy0, 1'b1);
    tick();
    chk("t2_busy_off", busy0, 1'b0);
    chk("t2_done_off", done0, 1'b0);
    check_writes("t2");

    // Count 1025 exceeds MAX_WORDS
    pulse_start();
    send_byte(8'h04, 0);
    send_byte(8'h01, 0);
    chk("t3_error", error0, 1'b1);
    chk("t3_busy", busy0, 1'b1);
    chk("t3_state_err", state0, 3'd6);
    tick();
    chk("t3_busy_off", busy0, 1'b0);
    chk("t3_ready_off", byte_ready0, 1'b0);
    repeat (3) tick();
    chk("t3_error_sticky", error0, 1'b1);
    chk("t3_state_idle", state0, 3'd0);
    pulse_start();
    chk("t3_error_cleared", error0, 1'b0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    chk("t3_done", done0, 1'b1);
    tick();
    check_writes("t3");

    // One-word load with valid gaps; high count bits [7:3] ignored; start ignored mid-load
    pulse_start();
    expect_write(11'd0, 32'h1234_5678);
    send_byte(8'hF8, 1);
    send_byte(8'h01, 1);
    send_byte(8'h12, 1);
    send_byte(8'h34, 1);
    pulse_start();
    chk("t4_start_ignored_state", state0, 3'd3);
    chk("t4_start_ignored_busy", busy0, 1'b1);
    send_byte(8'h56, 1);
    send_byte(8'h78, 1);
    chk("t4_strobe_latency", wr0, 1'b1);
    chk("t4_word", data0, 32'h1234_5678);
    chk("t4_addr1", addr1, 10'd1023);
    tick();
    chk("t4_done", done0, 1'b1);
    tick();
    check_writes("t4");

    // Reset after third data byte abandons the partial word
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    send_byte(8'hCC, 0);
    byte_in = 8'hDD;
    byte_valid = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    byte_valid = 1'b0;
    chk("t5_busy", busy0, 1'b0);
    chk("t5_ready", byte_ready0, 1'b0);
    chk("t5_state", state0, 3'd0);
    chk("t5_addr0", addr0, 10'd0);
    repeat (10) tick();
    chk("t5_still_idle", busy0, 1'b0);
    check_writes("t5");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 Parameter BASE_ADDRESS, default 10'd0, first instruction-RAM word address written by a load.
REQ-002 Parameter MAX_WORDS, default 1024, largest legal word count per load.
REQ-003 clock  input  1  single system clock; all logic SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to begin a load; sampled only in IDLE.
REQ-006 byte_in  input  8  incoming load-stream byte.
REQ-007 byte_valid  input  1  byte_in holds a valid byte.
REQ-008 byte_ready  output  1  loader accepts byte_in this cycle.
REQ-009 i_ram_input  output  32  assembled instruction word to the instruction RAM.
REQ-010 i_ram_writing_address  output  10  instruction RAM write address.
REQ-011 flag_write_i_ram  output  1  instruction RAM write strobe, one cycle per word.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse on successful load completion.
REQ-014 error  output  1  sticky flag: illegal word count received.

Function
REQ-015 States SHALL be IDLE, COUNT_HI, COUNT_LO, DATA, WRITE, FINISH, ERROR.
REQ-016 Byte transfer SHALL occur only on a cycle with byte_valid=1 and byte_ready=1.
REQ-017 byte_ready SHALL be 1 only in COUNT_HI, COUNT_LO and DATA, and 0 in all other states.
REQ-018 IDLE + start=1 -> COUNT_HI next cycle; start SHALL clear error.
REQ-019 COUNT_HI: accepted byte bits [2:0] -> count[10:8], bits [7:3] ignored; -> COUNT_LO.
REQ-020 COUNT_LO: accepted byte -> count[7:0]; next state: count=0 -> FINISH; count>MAX_WORDS -> ERROR; else DATA.
REQ-021 DATA: bytes SHALL be assembled big-endian, first byte -> word[31:24], fourth -> word[7:0].
REQ-022 Acceptance of the fourth byte -> WRITE next cycle; byte counter SHALL reset to 0.
REQ-023 WRITE lasts exactly one cycle: flag_write_i_ram=1, i_ram_input=assembled word, i_ram_writing_address=(BASE_ADDRESS+word_index) mod 1024.
REQ-024 Word-load latency: flag_write_i_ram SHALL assert the cycle after the fourth byte is accepted.
REQ-025 After WRITE, word_index SHALL increment; word_index=count -> FINISH, else DATA.
REQ-026 Address arithmetic SHALL be 10-bit and wrap from 1023 to 0 without error.
REQ-027 FINISH lasts one cycle with done=1, then -> IDLE.
REQ-028 ERROR: error=1, busy=1 for one cycle, then -> IDLE with error held at 1 until next start or reset.
REQ-029 Gaps in byte_valid SHALL stall the FSM in its current state with all assembled state held.
REQ-030 start outside IDLE SHALL be ignored.
REQ-031 flag_write_i_ram SHALL never assert outside WRITE; i_ram_input and i_ram_writing_address are don't-care when it is 0.
REQ-032 Partial words pending when a load is aborted by reset SHALL never be written.

Reset
REQ-033 reset=1 SHALL force IDLE on the next rising edge, overriding all other inputs including start.
REQ-034 After reset: byte_ready=0, flag_write_i_ram=0, busy=0, done=0, error=0, i_ram_input=0, i_ram_writing_address=BASE_ADDRESS, count=0, word_index=0, byte counter=0.
REQ-035 Reset asserted mid-load SHALL abandon the load without any further write strobe.

Verification
REQ-036 start; bytes 00,02, 6C,00,00,00, 74,40,00,00 -> writes 0x6C000000@0, then 0x74400000@1, then done pulse; exactly two strobes.
REQ-037 start; bytes 00,00 -> no write strobe, done pulse 1 cycle after second byte, busy low next cycle.
REQ-038 start; bytes 04,01 (count 1025) -> error=1, no strobe, IDLE; next start clears error.
REQ-039 BASE_ADDRESS=1023, count 2 -> writes at address 1023 then 0, error stays 0.
REQ-040 byte_valid toggled every other cycle during a 1-word load -> same word/address as back-to-back case; strobe exactly 1 cycle after 4th accepted byte.
REQ-041 reset asserted after 3rd data byte -> next cycle busy=0, byte_ready=0, no strobe ever issued for that word.
